// File: rtl/regs_wport_arbiter.sv
// regs_wport_arbiter
// Shares the register file's single write port among the WB stage, a
// one-entry MDU result buffer and the debug write interface.
// Priority is WB > buffered MDU result > debug. The buffer contents are
// exposed for forwarding. If WB traffic keeps the buffer from draining for
// too long, a pipeline stall is requested so that a WB bubble appears.

module regs_wport_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CPU_WIDTH      = 32,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      wb_wen_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [CPU_WIDTH-1:0]      wb_wdata_i,

    input  logic                      mdu_valid_i,
    output logic                      mdu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] mdu_waddr_i,
    input  logic [CPU_WIDTH-1:0]      mdu_wdata_i,

    input  logic                      dbg_req_i,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_waddr_i,
    input  logic [CPU_WIDTH-1:0]      dbg_wdata_i,
    output logic                      dbg_ack_o,

    output logic                      reg_wen_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [CPU_WIDTH-1:0]      reg_wdata_o,

    output logic                      pend_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] pend_addr_o,
    output logic [CPU_WIDTH-1:0]      pend_data_o,

    output logic                      pipe_stall_o
);

    // The counter must be able to hold STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        DBG_IDLE     = 2'd0,
        DBG_ACK      = 2'd1,
        DBG_WAIT_LOW = 2'd2
    } dbgState_t;

    // One-entry MDU buffer
    logic                      bufFull_q, bufFull_d;
    logic [REG_ADDR_WIDTH-1:0] bufAddr_q, bufAddr_d;
    logic [CPU_WIDTH-1:0]      bufData_q, bufData_d;

    // Starvation tracking
    logic [CNT_W-1:0]          starveCnt_q, starveCnt_d;
    logic                      stall_q, stall_d;

    // Debug handshake
    dbgState_t                 dbgState_q, dbgState_d;

    // Per-cycle arbitration decisions
    logic                      mduAccept;
    logic                      bufDrain;
    logic                      bufBlocked;
    logic                      dbgGrant;

    // Write-port selection
    logic                      selValid;
    logic [REG_ADDR_WIDTH-1:0] selAddr;
    logic [CPU_WIDTH-1:0]      selData;

    // While reset is asserted no source is granted, so nothing that is about
    // to be discarded can leak into the register file.
    always_comb begin
        mduAccept  = mdu_valid_i && !bufFull_q;
        bufDrain   = bufFull_q && !wb_wen_i;
        bufBlocked = bufFull_q && wb_wen_i;
        dbgGrant   = (dbgState_q == DBG_IDLE) && dbg_req_i && !wb_wen_i
                     && !bufFull_q && !rst_i;
    end

    // Pick the write-port source by fixed priority WB > buffer > debug.
    always_comb begin
        selValid = 1'b0;
        selAddr  = '0;
        selData  = '0;
        if (!rst_i) begin
            if (wb_wen_i) begin
                selValid = 1'b1;
                selAddr  = wb_waddr_i;
                selData  = wb_wdata_i;
            end else if (bufDrain) begin
                selValid = 1'b1;
                selAddr  = bufAddr_q;
                selData  = bufData_q;
            end else if (dbgGrant) begin
                selValid = 1'b1;
                selAddr  = dbg_waddr_i;
                selData  = dbg_wdata_i;
            end
        end
    end

    // x0 is hardwired: the source is still consumed but the enable is dropped.
    always_comb begin
        reg_wen_o   = selValid && (selAddr != '0);
        reg_waddr_o = selAddr;
        reg_wdata_o = selData;
    end

    // Buffer next state: capture on accept, release on drain. The contents
    // are kept after a drain so the forwarding outputs stay stable.
    always_comb begin
        bufFull_d = bufFull_q;
        bufAddr_d = bufAddr_q;
        bufData_d = bufData_q;
        if (mduAccept) begin
            bufFull_d = 1'b1;
            bufAddr_d = mdu_waddr_i;
            bufData_d = mdu_wdata_i;
        end else if (bufDrain) begin
            bufFull_d = 1'b0;
        end
    end

    // Count blocked cycles, saturating at the limit; raise the stall on the
    // edge where the limit is reached and drop it on the drain edge.
    always_comb begin
        starveCnt_d = starveCnt_q;
        stall_d     = stall_q;
        if (bufDrain) begin
            starveCnt_d = '0;
            stall_d     = 1'b0;
        end else if (bufBlocked && (starveCnt_q != LIMIT)) begin
            starveCnt_d = starveCnt_q + CNT_W'(1);
            if (starveCnt_d == LIMIT) begin
                stall_d = 1'b1;
            end
        end
    end

    // Debug four-phase handshake: write on grant, ack one cycle, wait for the
    // request to drop so a held request cannot cause a second write.
    always_comb begin
        dbgState_d = dbgState_q;
        case (dbgState_q)
            DBG_IDLE: begin
                if (dbgGrant) begin
                    dbgState_d = DBG_ACK;
                end
            end
            DBG_ACK: begin
                dbgState_d = DBG_WAIT_LOW;
            end
            DBG_WAIT_LOW: begin
                if (!dbg_req_i) begin
                    dbgState_d = DBG_IDLE;
                end
            end
            default: begin
                dbgState_d = DBG_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any buffered
    // result and abandons an in-flight debug handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bufFull_q   <= 1'b0;
            bufAddr_q   <= '0;
            bufData_q   <= '0;
            starveCnt_q <= '0;
            stall_q     <= 1'b0;
            dbgState_q  <= DBG_IDLE;
        end else begin
            bufFull_q   <= bufFull_d;
            bufAddr_q   <= bufAddr_d;
            bufData_q   <= bufData_d;
            starveCnt_q <= starveCnt_d;
            stall_q     <= stall_d;
            dbgState_q  <= dbgState_d;
        end
    end

    // Status outputs come straight from registers; the ack is suppressed
    // while reset is held so an abandoned handshake never acknowledges.
    always_comb begin
        mdu_ready_o  = !bufFull_q;
        pend_valid_o = bufFull_q;
        pend_addr_o  = bufAddr_q;
        pend_data_o  = bufData_q;
        pipe_stall_o = stall_q;
        dbg_ack_o    = (dbgState_q == DBG_ACK) && !rst_i;
    end

endmodule

// File: tb/tb_regs_wport_arbiter.sv
// Directed testbench for regs_wport_arbiter with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_regs_wport_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_wen_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        mdu_valid_i;
    logic        mdu_ready_o;
    logic [4:0]  mdu_waddr_i;
    logic [31:0] mdu_wdata_i;
    logic        dbg_req_i;
    logic [4:0]  dbg_waddr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        pend_valid_o;
    logic [4:0]  pend_addr_o;
    logic [31:0] pend_data_o;
    logic        pipe_stall_o;

    int tests    = 0;
    int failures = 0;

    regs_wport_arbiter #(
        .REG_ADDR_WIDTH(5),
        .CPU_WIDTH     (32),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb_wen_i    (wb_wen_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .mdu_valid_i (mdu_valid_i),
        .mdu_ready_o (mdu_ready_o),
        .mdu_waddr_i (mdu_waddr_i),
        .mdu_wdata_i (mdu_wdata_i),
        .dbg_req_i   (dbg_req_i),
        .dbg_waddr_i (dbg_waddr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_ack_o   (dbg_ack_o),
        .reg_wen_o   (reg_wen_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o),
        .pend_valid_o(pend_valid_o),
        .pend_addr_o (pend_addr_o),
        .pend_data_o (pend_data_o),
        .pipe_stall_o(pipe_stall_o)
    );

    // 10-unit clock
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Drive all sources for the current cycle.
    task automatic applyStimulus(input logic rst, input logic wbEn,
                                 input logic [4:0] wbA, input logic [31:0] wbD,
                                 input logic mdV, input logic [4:0] mdA,
                                 input logic [31:0] mdD, input logic dbR,
                                 input logic [4:0] dbA, input logic [31:0] dbD);
        rst_i       = rst;
        wb_wen_i    = wbEn;
        wb_waddr_i  = wbA;
        wb_wdata_i  = wbD;
        mdu_valid_i = mdV;
        mdu_waddr_i = mdA;
        mdu_wdata_i = mdD;
        dbg_req_i   = dbR;
        dbg_waddr_i = dbA;
        dbg_wdata_i = dbD;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic sampleMid();
        @(negedge clk_i);
    endtask

    initial begin
        // Reset with random inputs for two cycles
        applyStimulus(1'b1, 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                      5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd3, $urandom, 1'($urandom),
                      5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
        sampleMid();
        checkOutput("rst_wen",   32'(reg_wen_o),    32'd0);
        checkOutput("rst_ready", 32'(mdu_ready_o),  32'd1);
        checkOutput("rst_pend",  32'(pend_valid_o), 32'd0);
        checkOutput("rst_stall", 32'(pipe_stall_o), 32'd0);
        checkOutput("rst_ack",   32'(dbg_ack_o),    32'd0);
        checkOutput("rst_paddr", 32'(pend_addr_o),  32'd0);
        checkOutput("rst_pdata", pend_data_o,       32'd0);

        // Idle after reset
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("idle_wen",   32'(reg_wen_o),   32'd0);
        checkOutput("idle_waddr", 32'(reg_waddr_o), 32'd0);
        checkOutput("idle_wdata", reg_wdata_o,      32'd0);

        // MDU basic: accept at T, no bypass
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0);
        sampleMid();
        checkOutput("mdu_T_ready", 32'(mdu_ready_o), 32'd1);
        checkOutput("mdu_T_wen",   32'(reg_wen_o),   32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("mdu_T1_pend",  32'(pend_valid_o), 32'd1);
        checkOutput("mdu_T1_wen",   32'(reg_wen_o),    32'd1);
        checkOutput("mdu_T1_waddr", 32'(reg_waddr_o),  32'd5);
        checkOutput("mdu_T1_wdata", reg_wdata_o,       32'h1234);
        checkOutput("mdu_T1_ready", 32'(mdu_ready_o),  32'd0);
        nextCycle();
        sampleMid();
        checkOutput("mdu_T2_ready", 32'(mdu_ready_o),  32'd1);
        checkOutput("mdu_T2_pend",  32'(pend_valid_o), 32'd0);
        checkOutput("mdu_T2_wen",   32'(reg_wen_o),    32'd0);

        // Starvation: accept while WB is writing, then six blocked cycles
        nextCycle();
        applyStimulus(0, 1, 5'd3, 32'h111, 1, 5'd7, 32'hA5A5, 0, 0, 0);
        sampleMid();
        checkOutput("stv_acc_waddr", 32'(reg_waddr_o), 32'd3);
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            applyStimulus(0, 1, 5'd3, 32'h200 + 32'(k), 1, 5'd9, 32'h9999, 0, 0, 0);
            sampleMid();
            checkOutput($sformatf("stv_b%0d_wdata", k), reg_wdata_o, 32'h200 + 32'(k));
            checkOutput($sformatf("stv_b%0d_stall", k), 32'(pipe_stall_o),
                        (k >= 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("stv_b%0d_ready", k), 32'(mdu_ready_o), 32'd0);
            checkOutput($sformatf("stv_b%0d_pdata", k), pend_data_o, 32'hA5A5);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("stv_drain_wen",   32'(reg_wen_o),    32'd1);
        checkOutput("stv_drain_waddr", 32'(reg_waddr_o),  32'd7);
        checkOutput("stv_drain_wdata", reg_wdata_o,       32'hA5A5);
        checkOutput("stv_drain_stall", 32'(pipe_stall_o), 32'd1);
        nextCycle();
        sampleMid();
        checkOutput("stv_after_stall", 32'(pipe_stall_o), 32'd0);
        checkOutput("stv_after_pend",  32'(pend_valid_o), 32'd0);

        // Debug waits for WB for two cycles, writes in the third
        for (int k = 1; k <= 2; k++) begin
            nextCycle();
            applyStimulus(0, 1, 5'd1, 32'h1, 0, 0, 0, 1, 5'd10, 32'hDEAD_BEEF);
            sampleMid();
            checkOutput($sformatf("dbg_c%0d_waddr", k), 32'(reg_waddr_o), 32'd1);
            checkOutput($sformatf("dbg_c%0d_ack", k),   32'(dbg_ack_o),   32'd0);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 32'hDEAD_BEEF);
        sampleMid();
        checkOutput("dbg_c3_wen",   32'(reg_wen_o),   32'd1);
        checkOutput("dbg_c3_waddr", 32'(reg_waddr_o), 32'd10);
        checkOutput("dbg_c3_wdata", reg_wdata_o,      32'hDEAD_BEEF);
        checkOutput("dbg_c3_ack",   32'(dbg_ack_o),   32'd0);
        nextCycle();
        sampleMid();
        checkOutput("dbg_c4_ack", 32'(dbg_ack_o), 32'd1);
        checkOutput("dbg_c4_wen", 32'(reg_wen_o), 32'd0);
        for (int k = 5; k <= 6; k++) begin
            nextCycle();
            sampleMid();
            checkOutput($sformatf("dbg_c%0d_ack", k), 32'(dbg_ack_o), 32'd0);
            checkOutput($sformatf("dbg_c%0d_wen", k), 32'(reg_wen_o), 32'd0);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("dbg_low_wen", 32'(reg_wen_o), 32'd0);

        // Buffer beats debug when both are pending
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd12, 32'h55, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd13, 32'h66);
        sampleMid();
        checkOutput("bvd_buf_waddr", 32'(reg_waddr_o), 32'd12);
        checkOutput("bvd_buf_wdata", reg_wdata_o,      32'h55);
        nextCycle();
        sampleMid();
        checkOutput("bvd_dbg_waddr", 32'(reg_waddr_o), 32'd13);
        checkOutput("bvd_dbg_wdata", reg_wdata_o,      32'h66);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("bvd_ack", 32'(dbg_ack_o), 32'd1);
        nextCycle();

        // x0: MDU result consumed without a write
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("x0_mdu_pend", 32'(pend_valid_o), 32'd1);
        checkOutput("x0_mdu_wen",  32'(reg_wen_o),    32'd0);
        nextCycle();
        sampleMid();
        checkOutput("x0_mdu_clr",   32'(pend_valid_o), 32'd0);
        checkOutput("x0_mdu_ready", 32'(mdu_ready_o),  32'd1);

        // x0: debug write still acknowledged
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h77);
        sampleMid();
        checkOutput("x0_dbg_wen", 32'(reg_wen_o), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("x0_dbg_ack", 32'(dbg_ack_o), 32'd1);
        nextCycle();
        sampleMid();
        checkOutput("x0_dbg_ack_off", 32'(dbg_ack_o), 32'd0);

        // Reset mid-operation: buffer full and debug in ACK
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd6, 32'h66, 1, 5'd4, 32'h44);
        sampleMid();
        checkOutput("rmo_grant_waddr", 32'(reg_waddr_o), 32'd4);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("rmo_rst_wen", 32'(reg_wen_o), 32'd0);
        checkOutput("rmo_rst_ack", 32'(dbg_ack_o), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid();
        checkOutput("rmo_pend",  32'(pend_valid_o), 32'd0);
        checkOutput("rmo_ack",   32'(dbg_ack_o),    32'd0);
        checkOutput("rmo_wen",   32'(reg_wen_o),    32'd0);
        checkOutput("rmo_ready", 32'(mdu_ready_o),  32'd1);
        checkOutput("rmo_stall", 32'(pipe_stall_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
